instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and loader for the WISC-SP22 core. It is the inverse of the control decoder. It accepts decoded instruction fields (opcode, funct, register specifiers, immediate) over a valid/ready handshake and packs them into 16-bit instruction words in the encoding the decoder expects. It buffers the words in a small FIFO and streams them into instruction memory at consecutive halfword addresses. Bench and boot logic use it to load programs without a preassembled image.

## Interface
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- BASE_ADDR, 16'h0000, first memory address written after reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries a valid instruction.
- in_ready  out  1  encoder can accept; transfer on `in_valid && in_ready` at clock edge.
- in_opcode  in  5  instruction opcode [15:11].
- in_funct  in  2  R-format funct; must be 0 for non-funct opcodes.
- in_rs / in_rt / in_rd  in  3 each  register specifiers.
- in_imm  in  11  immediate/displacement, two's-complement value.
- mem_wr  out  1  head word valid for memory write.
- mem_stall  in  1  memory busy; write does not retire this cycle.
- mem_addr  out  16  write address.
- mem_data  out  16  encoded word.
- count  out  16  words retired to memory since reset.
- done  out  1  HALT word retired.
- err  out  1  sticky field-error flag.

## Operation
- Format by opcode:
  - Full-word formats:
    - HALT 00000, NOP 00001, RTI 00011: word = {op, 11'b0}.
    - J 00100, JAL 00110: {op, imm[10:0]}.
  - I1 format: 01000–01011, 10000, 10001, 10011, 10100–10111; word = {op, rs, rd, imm[4:0]}.
  - I2 format: 01100–01111, 11000, 10010, 00101, 00111, siic 00010; word = {op, rs, imm[7:0]}.
  - R format: 11001, 11010, 11011, 11100–11111; word = {op, rs, rt, rd, funct}.
    - BTR forces rt = 0 and funct = 0.
- Every 5-bit opcode is defined, so no opcode error exists.
- Error check: nonzero funct on an opcode other than 11010/11011 is an error.
- Accepted erroneous request:
  - Handshake completes.
  - Word is not enqueued.
  - err is set and stays set until rst.
- Retire: the head word retires on an edge where `mem_wr && !mem_stall`. On retire:
  - mem_addr += 2, wrapping 16'hFFFE → 16'h0000.
  - count += 1, wrapping 16'hFFFF → 0.
  - FIFO pops.
- Retiring a HALT word:
  - Sets done.
  - After that, in_ready = 0 until rst.
  - Words already queued behind the HALT still retire.
- in_ready = !full && !done.
  - Based on registered occupancy only.
  - A pop in the same cycle does not open a slot for a push when full.
- Simultaneous push and pop when not full: occupancy unchanged.
- With mem_stall high, mem_addr and mem_data hold.

## Timing
- Reset values:
  - in_ready = 1, mem_wr = 0, mem_data = 0.
  - mem_addr = BASE_ADDR, count = 0, done = 0, err = 0.
  - FIFO empty.
- Reset mid-operation flushes queued words; nothing retires in the reset cycle.
- Latency:
  - Request accepted at edge N → mem_wr = 1 with that word from cycle N+1, if the FIFO was empty.
  - Earliest retire is edge N+1.
- Throughput: 1 word/cycle with mem_stall low.
- mem_wr = FIFO not empty. mem_data and mem_addr come from registers and head storage; there is no combinational path from in_* to mem_*.
- err is set at the acceptance edge of the bad request.
- done is set at the retire edge of the HALT word.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined: each immediate must fit its field, otherwise it is an error (rejected, err set).
  - Sign-extended I1 (ADDI, SUBI, ST, LD, STU): −16..15.
  - Zero-extended I1 (XORI, ANDNI): 0..31.
  - Shift immediates: 0..15.
  - Sign-extended I2 (branches, LBI, JR, JALR): −128..127.
  - SLBI: 0..255.
  - siic: 0.
- Undefined: immediates are silently truncated to their field width. Only funct errors set err.

## Test plan
- ADDI, ADD, HALT loaded back-to-back from reset (ADDI rs=1 rd=2 imm=−3; ADD rs=1 rt=2 rd=3 funct=00; HALT):
  - 0x415D at 0x0000, 0xD94C at 0x0002, 0x0000 at 0x0004.
  - done is set at the third retire.
  - count = 3.
  - in_ready = 0 afterwards.
- Field placement:
  - J with imm = −2 → 0x27FE.
  - LBI rs=1 imm=−128 → 0xC180.
  - BTR rs=1 rt=5 rd=3 funct=01 → err set, no write.
- mem_stall held high for 10 cycles while DEPTH+1 requests are offered:
  - Exactly DEPTH are accepted.
  - in_ready = 0.
  - mem_addr and mem_data stay stable.
  - After release, all words retire in order, one per cycle.
- ADDI rs=1 rd=2 imm=16:
  - With INSTR_ENC_RANGE_CHECK_EN: err = 1, count unchanged.
  - Without it: 0x4150 written, err = 0.
- BASE_ADDR = 16'hFFFE, two NOPs:
  - Written at 0xFFFE, then 0x0000.
- rst asserted with 3 words queued: next cycle mem_wr = 0, mem_addr = BASE_ADDR, count = 0, err = 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded WISC-SP22 fields into 16-bit words and streams them to imem (`INSTR_ENC_RANGE_CHECK_EN adds immediate range errors).
// Latency: an accepted word drives mem_* from the next cycle; 1 word/cycle while mem_stall is low.
// Backpressure: in_ready drops when the FIFO is full (registered occupancy) or once a HALT word has retired.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [1:0]  in_funct,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [2:0]  in_rd,
  input  logic [10:0] in_imm,
  output logic        mem_wr,
  input  logic        mem_stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic [15:0] count,
  output logic        done,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_BTR  = 5'b11001;
  localparam logic [4:0] OP_ALU0 = 5'b11010;
  localparam logic [4:0] OP_ALU1 = 5'b11011;

  typedef enum logic [2:0] {
    FMT_BARE,
    FMT_JUMP,
    FMT_I1,
    FMT_I2,
    FMT_R
  } fmt_e;

  fmt_e          fmt;
  logic [15:0]   enc_word;
  logic          funct_err;
  logic          range_err;
  logic          field_err;

  logic [15:0]   fifo_q [DEPTH];
  logic [15:0]   fifo_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   count_q, count_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          empty;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [15:0]   head_word;
  logic          head_halt;

  // Opcode to instruction format; every 5-bit opcode maps somewhere.
  always_comb begin
    fmt = FMT_R;
    case (in_opcode)
      5'b00000, 5'b00001, 5'b00011:                fmt = FMT_BARE;
      5'b00100, 5'b00110:                          fmt = FMT_JUMP;
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10000, 5'b10001, 5'b10011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111:      fmt = FMT_I1;
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b10010, 5'b00101, 5'b00111,
      5'b00010:                                    fmt = FMT_I2;
      default:                                     fmt = FMT_R;
    endcase
  end

  always_comb begin
    enc_word = {in_opcode, 11'b0};
    case (fmt)
      FMT_JUMP: enc_word = {in_opcode, in_imm};
      FMT_I1:   enc_word = {in_opcode, in_rs, in_rd, in_imm[4:0]};
      FMT_I2:   enc_word = {in_opcode, in_rs, in_imm[7:0]};
      FMT_R: begin
        if (in_opcode == OP_BTR) begin
          enc_word = {in_opcode, in_rs, 3'b000, in_rd, 2'b00};
        end else begin
          enc_word = {in_opcode, in_rs, in_rt, in_rd, in_funct};
        end
      end
      default:  enc_word = {in_opcode, 11'b0};
    endcase
  end

  assign funct_err = (in_funct != 2'b00) && (in_opcode != OP_ALU0) && (in_opcode != OP_ALU1);

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Upper immediate bits must be a pure sign or zero extension of the field.
  always_comb begin
    range_err = 1'b0;
    case (in_opcode)
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
        range_err = (in_imm[10:4] != {7{in_imm[4]}});
      5'b01010, 5'b01011:
        range_err = (in_imm[10:5] != 6'b0);
      5'b10100, 5'b10101, 5'b10110, 5'b10111:
        range_err = (in_imm[10:4] != 7'b0);
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b00101, 5'b00111:
        range_err = (in_imm[10:7] != {4{in_imm[7]}});
      5'b10010:
        range_err = (in_imm[10:8] != 3'b0);
      5'b00010:
        range_err = (in_imm != 11'b0);
      default:
        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign field_err = funct_err || range_err;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == FULL_OCC);
  assign in_ready  = !full && !done_q;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !field_err;
  assign pop       = !empty && !mem_stall;
  assign head_word = fifo_q[rd_ptr_q];
  assign head_halt = (head_word[15:11] == OP_HALT);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    done_d   = done_q;
    err_d    = err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      addr_d   = addr_q + 16'd2;
      count_d  = count_q + 16'd1;
      if (head_halt) begin
        done_d = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    // A rejected request still completes its handshake; only the flag records it.
    if (accept && field_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mem_wr   = !empty;
  assign mem_data = empty ? 16'h0000 : head_word;
  assign mem_addr = addr_q;
  assign count    = count_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
